// File: rtl/ib_rd_contr_b3.sv
// Block-3 input-buffer read controller: fetches DEPTH words per bank and streams them
// bit-serially MSB first, with bank k running k cycles behind bank 0.
module ib_rd_contr_b3 #(
    parameter int unsigned BANKS = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 14,
    localparam int unsigned AW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_done,
    input  logic [WIDTH-1:0] Din_0,  Din_1,  Din_2,  Din_3,
    input  logic [WIDTH-1:0] Din_4,  Din_5,  Din_6,  Din_7,
    input  logic [WIDTH-1:0] Din_8,  Din_9,  Din_10, Din_11,
    input  logic [WIDTH-1:0] Din_12, Din_13, Din_14, Din_15,
    output logic [AW-1:0]    ADDRB_0,  ADDRB_1,  ADDRB_2,  ADDRB_3,
    output logic [AW-1:0]    ADDRB_4,  ADDRB_5,  ADDRB_6,  ADDRB_7,
    output logic [AW-1:0]    ADDRB_8,  ADDRB_9,  ADDRB_10, ADDRB_11,
    output logic [AW-1:0]    ADDRB_12, ADDRB_13, ADDRB_14, ADDRB_15,
    output logic             ENB_0,  ENB_1,  ENB_2,  ENB_3,  ENB_4,  ENB_5,  ENB_6,  ENB_7,
    output logic             ENB_8,  ENB_9,  ENB_10, ENB_11, ENB_12, ENB_13, ENB_14, ENB_15,
    output logic             Bout_0,  Bout_1,  Bout_2,  Bout_3,  Bout_4,  Bout_5,  Bout_6,  Bout_7,
    output logic             Bout_8,  Bout_9,  Bout_10, Bout_11, Bout_12, Bout_13, Bout_14, Bout_15,
    output logic             Bout_0_Val,  Bout_1_Val,  Bout_2_Val,  Bout_3_Val,
    output logic             Bout_4_Val,  Bout_5_Val,  Bout_6_Val,  Bout_7_Val,
    output logic             Bout_8_Val,  Bout_9_Val,  Bout_10_Val, Bout_11_Val,
    output logic             Bout_12_Val, Bout_13_Val, Bout_14_Val, Bout_15_Val,
    output logic             busy,
    output logic             done
);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned DW = $clog2(BANKS);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, DONE_ST} state_t;

    state_t           state_q, state_d;
    logic             wr_prev_q;
    logic [AW-1:0]    fcnt_q, fcnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [BW-1:0]    bit_q;
    logic             busy_d, done_d, enb0_d, val0_d;
    logic [AW-1:0]    addr0_d;
    logic             start_c, last_bit_c;

    logic [WIDTH-1:0] din   [BANKS];
    logic [WIDTH-1:0] sr_q  [BANKS];
    logic [AW-1:0]    addr_q[BANKS];
    logic [BANKS-1:0] enb_q, ld_q, val_q;

    assign din[0]  = Din_0;  assign din[1]  = Din_1;  assign din[2]  = Din_2;  assign din[3]  = Din_3;
    assign din[4]  = Din_4;  assign din[5]  = Din_5;  assign din[6]  = Din_6;  assign din[7]  = Din_7;
    assign din[8]  = Din_8;  assign din[9]  = Din_9;  assign din[10] = Din_10; assign din[11] = Din_11;
    assign din[12] = Din_12; assign din[13] = Din_13; assign din[14] = Din_14; assign din[15] = Din_15;

    assign ENB_0  = enb_q[0];  assign ADDRB_0  = addr_q[0];  assign Bout_0  = sr_q[0][WIDTH-1];  assign Bout_0_Val  = val_q[0];
    assign ENB_1  = enb_q[1];  assign ADDRB_1  = addr_q[1];  assign Bout_1  = sr_q[1][WIDTH-1];  assign Bout_1_Val  = val_q[1];
    assign ENB_2  = enb_q[2];  assign ADDRB_2  = addr_q[2];  assign Bout_2  = sr_q[2][WIDTH-1];  assign Bout_2_Val  = val_q[2];
    assign ENB_3  = enb_q[3];  assign ADDRB_3  = addr_q[3];  assign Bout_3  = sr_q[3][WIDTH-1];  assign Bout_3_Val  = val_q[3];
    assign ENB_4  = enb_q[4];  assign ADDRB_4  = addr_q[4];  assign Bout_4  = sr_q[4][WIDTH-1];  assign Bout_4_Val  = val_q[4];
    assign ENB_5  = enb_q[5];  assign ADDRB_5  = addr_q[5];  assign Bout_5  = sr_q[5][WIDTH-1];  assign Bout_5_Val  = val_q[5];
    assign ENB_6  = enb_q[6];  assign ADDRB_6  = addr_q[6];  assign Bout_6  = sr_q[6][WIDTH-1];  assign Bout_6_Val  = val_q[6];
    assign ENB_7  = enb_q[7];  assign ADDRB_7  = addr_q[7];  assign Bout_7  = sr_q[7][WIDTH-1];  assign Bout_7_Val  = val_q[7];
    assign ENB_8  = enb_q[8];  assign ADDRB_8  = addr_q[8];  assign Bout_8  = sr_q[8][WIDTH-1];  assign Bout_8_Val  = val_q[8];
    assign ENB_9  = enb_q[9];  assign ADDRB_9  = addr_q[9];  assign Bout_9  = sr_q[9][WIDTH-1];  assign Bout_9_Val  = val_q[9];
    assign ENB_10 = enb_q[10]; assign ADDRB_10 = addr_q[10]; assign Bout_10 = sr_q[10][WIDTH-1]; assign Bout_10_Val = val_q[10];
    assign ENB_11 = enb_q[11]; assign ADDRB_11 = addr_q[11]; assign Bout_11 = sr_q[11][WIDTH-1]; assign Bout_11_Val = val_q[11];
    assign ENB_12 = enb_q[12]; assign ADDRB_12 = addr_q[12]; assign Bout_12 = sr_q[12][WIDTH-1]; assign Bout_12_Val = val_q[12];
    assign ENB_13 = enb_q[13]; assign ADDRB_13 = addr_q[13]; assign Bout_13 = sr_q[13][WIDTH-1]; assign Bout_13_Val = val_q[13];
    assign ENB_14 = enb_q[14]; assign ADDRB_14 = addr_q[14]; assign Bout_14 = sr_q[14][WIDTH-1]; assign Bout_14_Val = val_q[14];
    assign ENB_15 = enb_q[15]; assign ADDRB_15 = addr_q[15]; assign Bout_15 = sr_q[15][WIDTH-1]; assign Bout_15_Val = val_q[15];

    assign start_c    = wr_done & ~wr_prev_q;
    assign last_bit_c = val_q[0] && (bit_q == BW'(WIDTH - 1)) && !ld_q[0];

    // Bank-0 control FSM state and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_prev_q <= 1'b1;
            fcnt_q    <= '0;
            drain_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_prev_q <= wr_done;
            fcnt_q    <= fcnt_d;
            drain_q   <= drain_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        drain_d = '0;
        enb0_d  = 1'b0;
        addr0_d = '0;
        case (state_q)
            IDLE, DONE_ST: begin
                if (start_c) begin
                    state_d = FETCH;
                    enb0_d  = 1'b1;
                    addr0_d = AW'(1);
                    fcnt_d  = AW'(1);
                end
            end
            FETCH: state_d = SHIFT;
            SHIFT: begin
                // Issue the next read two bits early so it lands as the last bit leaves
                if (val_q[0] && (bit_q == BW'(WIDTH - 3)) && (fcnt_q < AW'(DEPTH))) begin
                    enb0_d  = 1'b1;
                    addr0_d = fcnt_q + AW'(1);
                    fcnt_d  = fcnt_q + AW'(1);
                end
                if (last_bit_c) state_d = DRAIN;
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(BANKS - 2)) state_d = DONE_ST;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == SHIFT) || (state_d == DRAIN);
        done_d = (state_d == DONE_ST);
        val0_d = ld_q[0] ? 1'b1 : (last_bit_c ? 1'b0 : val_q[0]);
    end

    // Per-bank delay lines and shift registers; bank k trails bank k-1 by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            enb_q <= '0;
            ld_q  <= '0;
            val_q <= '0;
            bit_q <= '0;
            for (int k = 0; k < BANKS; k++) begin
                addr_q[k] <= '0;
                sr_q[k]   <= '0;
            end
        end else begin
            enb_q     <= {enb_q[BANKS-2:0], enb0_d};
            ld_q      <= enb_q;
            val_q     <= {val_q[BANKS-2:0], val0_d};
            addr_q[0] <= addr0_d;
            for (int k = 1; k < BANKS; k++) addr_q[k] <= addr_q[k-1];
            for (int k = 0; k < BANKS; k++) sr_q[k] <= ld_q[k] ? din[k] : (sr_q[k] << 1);
            bit_q <= ld_q[0] ? '0 : (val_q[0] ? bit_q + BW'(1) : '0);
        end
    end
endmodule

// File: tb/tb_ib_rd_contr_b3.sv
// Bench for ib_rd_contr_b3: RAM model plus a cycle-offset reference of every bank's
// fetch pulses, bit stream and status, checked every cycle.
module tb_ib_rd_contr_b3;
    localparam int FRAME_BITS = 14 * 32;
    localparam int BUSY_LAST  = FRAME_BITS + 2 + 15;
    localparam int DONE_AT    = BUSY_LAST + 1;

    logic clk, rst, wr_done, busy, done;
    logic [15:0][31:0] din_v;
    logic [15:0][3:0]  addr_v;
    logic [15:0]       enb_v, bout_v, val_v;

    logic [31:0] mem [16][16];
    int  cyc, m_start, checks, errors, val_cnt, one_cnt;
    bit  m_prev;

    ib_rd_contr_b3 dut (
        .clk(clk), .rst(rst), .wr_done(wr_done), .busy(busy), .done(done),
        .Din_0(din_v[0]),   .ADDRB_0(addr_v[0]),   .ENB_0(enb_v[0]),   .Bout_0(bout_v[0]),   .Bout_0_Val(val_v[0]),
        .Din_1(din_v[1]),   .ADDRB_1(addr_v[1]),   .ENB_1(enb_v[1]),   .Bout_1(bout_v[1]),   .Bout_1_Val(val_v[1]),
        .Din_2(din_v[2]),   .ADDRB_2(addr_v[2]),   .ENB_2(enb_v[2]),   .Bout_2(bout_v[2]),   .Bout_2_Val(val_v[2]),
        .Din_3(din_v[3]),   .ADDRB_3(addr_v[3]),   .ENB_3(enb_v[3]),   .Bout_3(bout_v[3]),   .Bout_3_Val(val_v[3]),
        .Din_4(din_v[4]),   .ADDRB_4(addr_v[4]),   .ENB_4(enb_v[4]),   .Bout_4(bout_v[4]),   .Bout_4_Val(val_v[4]),
        .Din_5(din_v[5]),   .ADDRB_5(addr_v[5]),   .ENB_5(enb_v[5]),   .Bout_5(bout_v[5]),   .Bout_5_Val(val_v[5]),
        .Din_6(din_v[6]),   .ADDRB_6(addr_v[6]),   .ENB_6(enb_v[6]),   .Bout_6(bout_v[6]),   .Bout_6_Val(val_v[6]),
        .Din_7(din_v[7]),   .ADDRB_7(addr_v[7]),   .ENB_7(enb_v[7]),   .Bout_7(bout_v[7]),   .Bout_7_Val(val_v[7]),
        .Din_8(din_v[8]),   .ADDRB_8(addr_v[8]),   .ENB_8(enb_v[8]),   .Bout_8(bout_v[8]),   .Bout_8_Val(val_v[8]),
        .Din_9(din_v[9]),   .ADDRB_9(addr_v[9]),   .ENB_9(enb_v[9]),   .Bout_9(bout_v[9]),   .Bout_9_Val(val_v[9]),
        .Din_10(din_v[10]), .ADDRB_10(addr_v[10]), .ENB_10(enb_v[10]), .Bout_10(bout_v[10]), .Bout_10_Val(val_v[10]),
        .Din_11(din_v[11]), .ADDRB_11(addr_v[11]), .ENB_11(enb_v[11]), .Bout_11(bout_v[11]), .Bout_11_Val(val_v[11]),
        .Din_12(din_v[12]), .ADDRB_12(addr_v[12]), .ENB_12(enb_v[12]), .Bout_12(bout_v[12]), .Bout_12_Val(val_v[12]),
        .Din_13(din_v[13]), .ADDRB_13(addr_v[13]), .ENB_13(enb_v[13]), .Bout_13(bout_v[13]), .Bout_13_Val(val_v[13]),
        .Din_14(din_v[14]), .ADDRB_14(addr_v[14]), .ENB_14(enb_v[14]), .Bout_14(bout_v[14]), .Bout_14_Val(val_v[14]),
        .Din_15(din_v[15]), .ADDRB_15(addr_v[15]), .ENB_15(enb_v[15]), .Bout_15(bout_v[15]), .Bout_15_Val(val_v[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_busy(input int c);
        return (m_start >= 0) && (c - m_start >= 1) && (c - m_start <= BUSY_LAST);
    endfunction

    // Reference: every output is a function of the offset from the last accepted edge
    task automatic expect_at(input int c, output logic [15:0] e_enb, output logic [15:0][3:0] e_addr,
                             output logic [15:0] e_val, output logic [15:0] e_bout,
                             output logic e_busy, output logic e_done);
        int d;
        logic [31:0] word;
        e_enb = '0; e_addr = '0; e_val = '0; e_bout = '0;
        e_busy = is_busy(c);
        e_done = (m_start >= 0) && (c - m_start >= DONE_AT);
        if (m_start >= 0) begin
            for (int k = 0; k < 16; k++) begin
                d = c - m_start - k;
                if (d >= 1 && d <= 1 + 13 * 32 && (d - 1) % 32 == 0) begin
                    e_enb[k]  = 1'b1;
                    e_addr[k] = 4'((d - 1) / 32 + 1);
                end
                if (d >= 3 && d < 3 + FRAME_BITS) begin
                    word      = mem[k][(d - 3) / 32 + 1];
                    e_val[k]  = 1'b1;
                    e_bout[k] = word[31 - (d - 3) % 32];
                end
            end
        end
    endtask

    task automatic tick();
        logic [15:0]       en_s, e_enb, e_val, e_bout;
        logic [15:0][3:0]  ad_s, e_addr;
        logic              e_busy, e_done;
        en_s = enb_v;
        ad_s = addr_v;
        if (rst) begin
            m_start = -1;
            m_prev  = 1'b1;
        end else begin
            if (wr_done && !m_prev && !is_busy(cyc)) m_start = cyc;
            m_prev = wr_done;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 16; k++) din_v[k] = (en_s[k] === 1'b1) ? mem[k][ad_s[k]] : $urandom;
        expect_at(cyc, e_enb, e_addr, e_val, e_bout, e_busy, e_done);
        chk("enb",  64'(enb_v),  64'(e_enb));
        chk("addr", 64'(addr_v), 64'(e_addr));
        chk("val",  64'(val_v),  64'(e_val));
        chk("bout", 64'(bout_v), 64'(e_bout));
        chk("busy", 64'(busy),   64'(e_busy));
        chk("done", 64'(done),   64'(e_done));
        if (val_v[0] === 1'b1) begin
            val_cnt++;
            one_cnt += int'(bout_v[0]);
        end
    endtask

    task automatic start_edge();
        wr_done = 1'b0;
        tick();
        wr_done = 1'b1;
        tick();
    endtask

    task automatic rand_mem();
        for (int k = 0; k < 16; k++)
            for (int a = 0; a < 16; a++) mem[k][a] = $urandom;
    endtask

    initial begin
        int r;
        cyc = 0; m_start = -1; m_prev = 1'b1; checks = 0; errors = 0; val_cnt = 0; one_cnt = 0;
        rst = 1'b1; wr_done = 1'b1; din_v = '0;
        for (int k = 0; k < 16; k++)
            for (int a = 0; a < 16; a++) mem[k][a] = {4'(k), 4'(a), 24'hA5C3F0};

        // Reset with wr_done already high, then power-up: no frame may start
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("pwr_busy", 64'(busy), 64'(0));

        // Basic frame with a wr_done toggle while busy that must be ignored
        val_cnt = 0;
        start_edge();
        repeat (100) tick();
        wr_done = 1'b0; tick();
        wr_done = 1'b1; tick();
        repeat (380) tick();
        chk("frame1_bits", 64'(val_cnt), 64'(FRAME_BITS));

        // Random data, reset mid-frame with wr_done held high, then a clean restart
        rand_mem();
        start_edge();
        repeat (198) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("no_restart", 64'(busy), 64'(0));
        val_cnt = 0;
        start_edge();
        repeat (480) tick();
        chk("frame2_bits", 64'(val_cnt), 64'(FRAME_BITS));

        // Continuity: bank 0 all ones except word 14
        for (int a = 1; a <= 14; a++) mem[0][a] = (a == 14) ? 32'h0 : 32'hFFFF_FFFF;
        val_cnt = 0; one_cnt = 0;
        start_edge();
        repeat (480) tick();
        chk("cont_val", 64'(val_cnt), 64'(FRAME_BITS));
        chk("cont_ones", 64'(one_cnt), 64'(13 * 32));

        // Re-trigger from done, with a random toggle during busy
        rand_mem();
        r = int'($urandom_range(5, 440));
        val_cnt = 0;
        start_edge();
        repeat (r) tick();
        wr_done = 1'b0; tick();
        wr_done = 1'b1; tick();
        repeat (480 - r) tick();
        chk("frame4_bits", 64'(val_cnt), 64'(FRAME_BITS));
        val_cnt = 0;
        start_edge();
        repeat (480) tick();
        chk("frame5_bits", 64'(val_cnt), 64'(FRAME_BITS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
